// File: rtl/add_mult_sequencer_pkg.sv
// Shared types and constants for the shift-and-add multiplier sequencer.
package add_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mult_state_t;

   localparam int MULT_WIDTH = 32;
   localparam int MULT_CNT_W = 6;
   localparam int MULT_STEPS = 32;

   // True when either operand is zero, so the product is trivially zero.
   function automatic logic is_zero_operand(input logic [MULT_WIDTH-1:0] a,
                                            input logic [MULT_WIDTH-1:0] b);
      return (a == {MULT_WIDTH{1'b0}}) || (b == {MULT_WIDTH{1'b0}});
   endfunction

endpackage

// File: rtl/add_mult_sequencer_if.sv
// Start/busy/done request bus between the issuing control logic (master)
// and the multiplier sequencer (slave).
interface add_mult_sequencer_if;
   import add_mult_pkg::*;

   logic                      start;
   logic [MULT_WIDTH-1:0]     multiplicand;
   logic [MULT_WIDTH-1:0]     multiplier;
   logic                      busy;
   logic                      done;
   logic [2*MULT_WIDTH-1:0]   product;

   modport master (
      output start, multiplicand, multiplier,
      input  busy, done, product
   );

   modport slave (
      input  start, multiplicand, multiplier,
      output busy, done, product
   );

endinterface

// File: rtl/add_mult_sequencer.sv
// Sequential 32x32->64 unsigned multiplier control block. One partial
// product per clock is formed by an external shared 32-bit adder reached
// through the add_* ports. {hi,lo} is the running product/multiplier pair:
// each RUN step adds the multiplicand into hi when lo[0] is set, then
// shifts the 65-bit {carry, sum, lo} right by one.
// Optional feature macro: MULT_EARLY_TERM_EN (zero operand -> DONE at once).
module add_mult_sequencer
   import add_mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH,
   parameter int CNT_W = MULT_CNT_W
)(
   input  logic                 clk,
   input  logic                 reset,
   add_mult_sequencer_if.slave  bus,
   output logic [WIDTH-1:0]     add_a,
   output logic [WIDTH-1:0]     add_b,
   input  logic [WIDTH-1:0]     add_sum,
   input  logic                 add_cout
);

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   mult_state_t          state_q,   state_d;
   logic [WIDTH-1:0]     hi_q,      hi_d;
   logic [WIDTH-1:0]     lo_q,      lo_d;
   logic [WIDTH-1:0]     mcand_q,   mcand_d;
   logic [CNT_W-1:0]     cnt_q,     cnt_d;
   logic [2*WIDTH-1:0]   product_q, product_d;

   // Next-state and datapath update for the IDLE/RUN/DONE sequence.
   always_comb begin
      state_d   = state_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      mcand_d   = mcand_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               mcand_d = bus.multiplicand;
               hi_d    = {WIDTH{1'b0}};
               lo_d    = bus.multiplier;
               cnt_d   = {CNT_W{1'b0}};
`ifdef MULT_EARLY_TERM_EN
               if (is_zero_operand(bus.multiplicand, bus.multiplier)) begin
                  // Product is trivially zero; skip the adder entirely.
                  state_d   = DONE;
                  product_d = {(2*WIDTH){1'b0}};
               end else begin
                  state_d = RUN;
               end
`else
               state_d = RUN;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            // Carry out becomes the new top bit so the 64-bit result is exact.
            hi_d  = {add_cout, add_sum[WIDTH-1:1]};
            lo_d  = {add_sum[0], lo_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) begin
               state_d   = DONE;
               product_d = {hi_d, lo_d};
            end else begin
               state_d = RUN;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         hi_q      <= {WIDTH{1'b0}};
         lo_q      <= {WIDTH{1'b0}};
         mcand_q   <= {WIDTH{1'b0}};
         cnt_q     <= {CNT_W{1'b0}};
         product_q <= {(2*WIDTH){1'b0}};
      end else begin
         state_q   <= state_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         mcand_q   <= mcand_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   // Adder operands: only driven while stepping, zero otherwise.
   always_comb begin
      if (state_q == RUN) begin
         add_a = hi_q;
         if (lo_q[0]) begin
            add_b = mcand_q;
         end else begin
            add_b = {WIDTH{1'b0}};
         end
      end else begin
         add_a = {WIDTH{1'b0}};
         add_b = {WIDTH{1'b0}};
      end
   end

   // Status outputs decoded directly from registered state.
   always_comb begin
      bus.busy    = (state_q != IDLE);
      bus.done    = (state_q == DONE);
      bus.product = product_q;
   end

endmodule

// File: tb/tb_add_mult_sequencer.sv
// Scoreboard bench for add_mult_sequencer: the stimulus pushes expected
// products with their due cycle, a negedge monitor pops on every done.
module tb_add_mult_sequencer;
   import add_mult_pkg::*;

`ifdef MULT_EARLY_TERM_EN
   localparam int LAT_ZERO = 0;
`else
   localparam int LAT_ZERO = 32;
`endif
   localparam int LAT_FULL = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] add_a, add_b, add_sum;
   logic        add_cout;

   add_mult_sequencer_if bus();

   add_mult_sequencer dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_sum  (add_sum),
      .add_cout (add_cout)
   );

   // The shared adder, modelled next to the block.
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] prod;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_done  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected product and cycle.
   always @(negedge clk) begin
      exp_t e;
      if (reset === 1'b1 && bus.done === 1'b1) begin
         n_done++;
         check("done_expected", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("product", bus.product, e.prod);
            check("done_cycle", 64'(cyc), 64'(e.due));
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat);
      @(negedge clk);
      bus.start        = 1'b1;
      bus.multiplicand = a;
      bus.multiplier   = b;
      @(posedge clk);
      #1;
      sb.push_back('{exp, cyc + lat});
      bus.start        = 1'b0;
      bus.multiplicand = 32'hDEAD_BEEF;
      bus.multiplier   = 32'hDEAD_BEEF;
   endtask

   task automatic drain(input int budget);
      int k;
      k = 0;
      while (sb.size() != 0 && k < budget) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("drain", 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   initial begin
      int busy_cnt;
      int done_base;
      int e0;
      logic [63:0] mixed_exp;

      reset            = 1'b0;
      bus.start        = 1'b0;
      bus.multiplicand = 32'd0;
      bus.multiplier   = 32'd0;
      #12;
      check("reset_busy", 64'(bus.busy), 64'd0);
      check("reset_done", 64'(bus.done), 64'd0);
      check("reset_product", bus.product, 64'd0);
      @(negedge clk);
      reset = 1'b1;

      // Basic and carry-path products.
      issue(32'd3, 32'd5, 64'h0000_0000_0000_000F, LAT_FULL);
      drain(60);
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, LAT_FULL);
      drain(60);

      // Mixed operands with busy-length measurement (32 RUN + 1 DONE cycles).
      mixed_exp = 64'(32'h427D_316E) * 64'(32'h825F_910A);
      issue(32'h427D_316E, 32'h825F_910A, mixed_exp, LAT_FULL);
      busy_cnt = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.busy) busy_cnt++;
         else break;
      end
      check("busy_cycles", 64'(busy_cnt), 64'd33);
      drain(60);

      // start during RUN is ignored: only one done, product from first operands.
      done_base = n_done;
      issue(32'd6, 32'd7, 64'd42, LAT_FULL);
      repeat (9) @(negedge clk);
      bus.start        = 1'b1;
      bus.multiplicand = 32'd100;
      bus.multiplier   = 32'd100;
      @(negedge clk);
      bus.start = 1'b0;
      drain(60);
      repeat (40) @(negedge clk);
      check("ignored_start_dones", 64'(n_done - done_base), 64'd1);

      // Asynchronous reset in the middle of RUN.
      issue(32'd11, 32'd13, 64'd143, LAT_FULL);
      repeat (14) @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("midrun_busy", 64'(bus.busy), 64'd0);
      check("midrun_done", 64'(bus.done), 64'd0);
      check("midrun_product", bus.product, 64'd0);
      sb.delete();
      @(negedge clk);
      reset = 1'b1;
      issue(32'd7, 32'd9, 64'd63, LAT_FULL);
      drain(60);

      // Zero operand.
      issue(32'd0, 32'h1234_5678, 64'd0, LAT_ZERO);
      drain(60);

      // Back-to-back with start held high: second accepted 34 edges later.
      done_base = n_done;
      @(negedge clk);
      bus.start        = 1'b1;
      bus.multiplicand = 32'h0001_0000;
      bus.multiplier   = 32'h0001_0000;
      @(posedge clk);
      #1;
      e0 = cyc;
      sb.push_back('{64'h0000_0001_0000_0000, e0 + 32});
      sb.push_back('{64'h0000_0001_0000_0000, e0 + 66});
      repeat (34) @(posedge clk);
      #1;
      bus.start = 1'b0;
      drain(100);
      repeat (40) @(negedge clk);
      check("b2b_dones", 64'(n_done - done_base), 64'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
